alu_multicycle: RTL and testbench



---
 rtl/alu_defs_pkg.sv | 28 ++
 rtl/alu_comb_core.sv | 29 ++
 rtl/alu_multicycle.sv | 138 +++++++++++++
 tb/tb_alu_multicycle.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared opcode and FSM-state definitions for the multi-cycle ALU and its combinational core.
package alu_defs;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOT  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_SLLV = 4'b0111;
  localparam logic [3:0] ALU_SRA1 = 4'b1000;
  localparam logic [3:0] ALU_SLL1 = 4'b1001;
  localparam logic [3:0] ALU_SRL1 = 4'b1010;
  localparam logic [3:0] ALU_ROL1 = 4'b1100;
  localparam logic [3:0] ALU_ROR1 = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // A zero-amount SLLV degenerates to a pass-through and skips the iterator.
  function automatic logic is_iterative(input logic [3:0] op, input logic shamt_nonzero);
    return (op == ALU_MUL) || ((op == ALU_SLLV) && shamt_nonzero);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational single-cycle ALU operations; MUL, SLLV and undefined opcodes yield 0.
module alu_comb_core #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  import alu_defs::*;

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_NOT:  y = ~a;
      ALU_SRA1: y = {a[WIDTH-1], a[WIDTH-1:1]};
      ALU_SLL1: y = {a[WIDTH-2:0], 1'b0};
      ALU_SRL1: y = {1'b0, a[WIDTH-1:1]};
      ALU_ROL1: y = {a[WIDTH-2:0], a[WIDTH-1]};
      ALU_ROR1: y = {a[0], a[WIDTH-1:1]};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle ops in one clock, iterative MUL and SLLV.
// Define ALU_OVERFLOW_EN to generate signed ADD/SUB overflow on Ovf; otherwise Ovf is tied to 0.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Ovf
);
  import alu_defs::*;

  localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] step_acc;
  logic [SHW-1:0]   shamt;

  assign shamt = B[SHW-1:0];

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op(Op),
    .a (A),
    .b (B),
    .y (core_y)
  );

  assign single_res = (Op == ALU_SLLV) ? A : core_y;

  // acc doubles as the product accumulator for MUL and the shifting value for SLLV.
  always_comb begin
    step_acc = acc;
    if (op_q == ALU_MUL) begin
      if (mplier[0]) step_acc = acc + mcand;
    end else begin
      step_acc = {acc[WIDTH-2:0], 1'b0};
    end
  end

  // FIN behaves like IDLE apart from the Done pulse, so a Start in the Done cycle is accepted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Out    <= '0;
      Zero   <= 1'b0;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_ITER: begin
          acc    <= step_acc;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= S_FIN;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Out   <= step_acc;
            Zero  <= (step_acc == '0);
          end
        end
        default: begin
          state <= S_IDLE;
          if (Start) begin
            op_q <= Op;
            if (is_iterative(Op, shamt != '0)) begin
              state  <= S_ITER;
              Busy   <= 1'b1;
              mcand  <= A;
              mplier <= B;
              if (Op == ALU_MUL) begin
                acc <= '0;
                cnt <= CNT_FULL;
              end else begin
                acc <= A;
                cnt <= {1'b0, shamt};
              end
            end else begin
              state <= S_FIN;
              Done  <= 1'b1;
              Out   <= single_res;
              Zero  <= (single_res == '0);
            end
          end
        end
      endcase
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_next;

  always_comb begin
    ovf_next = 1'b0;
    if (Op == ALU_ADD)
      ovf_next = (A[WIDTH-1] == B[WIDTH-1]) && (core_y[WIDTH-1] != A[WIDTH-1]);
    else if (Op == ALU_SUB)
      ovf_next = (A[WIDTH-1] != B[WIDTH-1]) && (core_y[WIDTH-1] != A[WIDTH-1]);
  end

  // Ovf is reloaded on every completion so it always describes the current Out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ovf <= 1'b0;
    end else if (state != S_ITER && Start && !is_iterative(Op, shamt != '0)) begin
      Ovf <= ovf_next;
    end else if (state == S_ITER && cnt == CNT_ONE) begin
      Ovf <= 1'b0;
    end
  end
`else
  assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: latency-based behavioural model checked every cycle
// plus directed vectors with hand-computed results (honours ALU_OVERFLOW_EN when defined).
module tb_alu_multicycle;
  localparam int W   = 32;
  localparam int SHW = $clog2(W);

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, ovf;
  logic [W-1:0] out;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .Done(done), .Out(out), .Zero(zero), .Ovf(ovf)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Result of each opcode written directly from its arithmetic definition.
  function automatic logic [W-1:0] model_result(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      4'h0:    return x + y;
      4'h1:    return x - y;
      4'h2:    return x & y;
      4'h3:    return x | y;
      4'h4:    return ~x;
      4'h5:    return x * y;
      4'h7:    return x << y[SHW-1:0];
      4'h8:    return $signed(x) >>> 1;
      4'h9:    return x << 1;
      4'hA:    return x >> 1;
      4'hC:    return (x << 1) | (x >> (W-1));
      4'hD:    return (x >> 1) | (x << (W-1));
      default: return '0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] o, input logic [W-1:0] y);
    if (o == 4'h5) return W + 1;
    if (o == 4'h7) return int'(y[SHW-1:0]) + 1;
    return 1;
  endfunction

  function automatic logic model_ovf(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r);
`ifdef ALU_OVERFLOW_EN
    if (o == 4'h0) return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    if (o == 4'h1) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
`endif
    return 1'b0;
  endfunction

  // Model state: cycles left on the in-flight op and what it will deliver.
  int           m_left = 0;
  logic [W-1:0] pend_out, exp_out, m_r;
  logic         pend_ovf, exp_ovf, exp_busy, exp_done, exp_zero, m_o;
  int           m_lat;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; exp_busy = 0; exp_done = 0; exp_out = '0; exp_zero = 0; exp_ovf = 0;
    end else begin
      exp_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_done = 1; exp_out = pend_out; exp_zero = (pend_out == '0); exp_ovf = pend_ovf;
        end
      end else if (start) begin
        m_r   = model_result(op, a, b);
        m_lat = model_latency(op, b);
        m_o   = model_ovf(op, a, b, m_r);
        if (m_lat == 1) begin
          exp_done = 1; exp_out = m_r; exp_zero = (m_r == '0); exp_ovf = m_o;
        end else begin
          m_left = m_lat - 1; pend_out = m_r; pend_ovf = m_o;
        end
      end
      exp_busy = (m_left > 0);
    end
    #1;
    if (check_en) begin
      checkOutput("cyc_busy", busy, exp_busy);
      checkOutput("cyc_done", done, exp_done);
      checkOutput("cyc_out",  out,  exp_out);
      checkOutput("cyc_zero", zero, exp_zero);
      checkOutput("cyc_ovf",  ovf,  exp_ovf);
    end
  end

  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
  endtask

  // Counts clocks from the accepting edge until Done; optionally pokes Start while busy.
  task automatic waitDone(input string name, input int budget, input bit noise, output int lat);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      if (noise && lat == 5) begin start = 1'b1; op = 4'h0; a = 32'd1; b = 32'd2; end
      if (noise && lat == 9) start = 1'b0;
    end
    checkOutput({name, "_done_seen"}, done, 1'b1);
  endtask

  task automatic runOp(input string name, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp_y, input int exp_lat, input bit noise);
    int lat;
    @(negedge clk);
    applyStimulus(o, x, y);
    waitDone(name, exp_lat + 4, noise, lat);
    checkOutput({name, "_lat"},  lat,  exp_lat);
    checkOutput({name, "_out"},  out,  exp_y);
    checkOutput({name, "_zero"}, zero, exp_y == '0);
  endtask

  initial begin
    int lat;
    int done_seen;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_out",  out,  32'd0);
    checkOutput("rst_zero", zero, 1'b0);
    checkOutput("rst_ovf",  ovf,  1'b0);

    runOp("add", 4'h0, 32'd5, 32'd7, 32'd12, 1, 0);
    @(posedge clk); #1;
    checkOutput("add_busy_after", busy, 1'b0);
    checkOutput("add_done_pulse", done, 1'b0);

    runOp("sub_zero", 4'h1, 32'h1234, 32'h1234, 32'h0, 1, 0);
    runOp("add_wrap", 4'h0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 0);
`ifdef ALU_OVERFLOW_EN
    checkOutput("add_ovf", ovf, 1'b1);
`else
    checkOutput("add_ovf", ovf, 1'b0);
`endif
    runOp("and",  4'h2, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 1, 0);
    runOp("or",   4'h3, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1, 0);
    runOp("sra1", 4'h8, 32'h8000_0004, 32'd0, 32'hC000_0002, 1, 0);
    runOp("sll1", 4'h9, 32'hC000_0001, 32'd0, 32'h8000_0002, 1, 0);
    runOp("srl1", 4'hA, 32'h8000_0000, 32'd0, 32'h4000_0000, 1, 0);
    runOp("rol1", 4'hC, 32'h8000_0001, 32'd0, 32'h0000_0003, 1, 0);
    runOp("ror1", 4'hD, 32'h0000_0001, 32'd0, 32'h8000_0000, 1, 0);

    runOp("mul_ffff", 4'h5, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33, 1);
    runOp("mul_shift", 4'h5, 32'h1234_5678, 32'h10, 32'h2345_6780, 33, 0);
    runOp("sllv_31",  4'h7, 32'd1, 32'd31, 32'h8000_0000, 32, 0);
    runOp("sllv_0",   4'h7, 32'd1, 32'd0, 32'd1, 1, 0);
    runOp("sllv_32",  4'h7, 32'h0000_ABCD, 32'd32, 32'h0000_ABCD, 1, 0);
    runOp("sllv_4",   4'h7, 32'h8000_0001, 32'd4, 32'h0000_0010, 5, 0);

    // Abort a MUL partway through with reset.
    @(negedge clk);
    applyStimulus(4'h5, 32'd3, 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_out",  out,  32'd0);
    checkOutput("abort_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    runOp("add_after_abort", 4'h0, 32'd2, 32'd3, 32'd5, 1, 0);

    // Back-to-back: issue NOT in the Done cycle of an ADD.
    runOp("b2b_add", 4'h0, 32'd3, 32'd4, 32'd7, 1, 0);
    applyStimulus(4'h4, 32'd0, 32'd0);
    waitDone("b2b_not", 5, 0, lat);
    checkOutput("b2b_not_lat",  lat,  1);
    checkOutput("b2b_not_out",  out,  32'hFFFF_FFFF);
    checkOutput("b2b_not_zero", zero, 1'b0);

    runOp("undef", 4'hF, 32'd5, 32'd5, 32'd0, 1, 0);
    runOp("undef6", 4'h6, 32'hFFFF_FFFF, 32'd3, 32'd0, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
